hilo_mdu: RTL and testbench
===========================

HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL expose port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL expose port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL expose port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL expose port: op  input  2  operation select (MULT, MULTU, DIV, DIVU).
REQ-006 SHALL expose port: src_a  input  32  rs operand (multiplicand/dividend).
REQ-007 SHALL expose port: src_b  input  32  rt operand (multiplier/divisor).
REQ-008 SHALL expose port: flush  input  1  abort the in-flight operation with no writeback.
REQ-009 SHALL expose port: busy  output  1  high from the cycle after acceptance through the DONE cycle.
REQ-010 SHALL expose port: RFWr  output  1  one-cycle write strobe to the register file HI/LO pair.
REQ-011 SHALL expose port: MDIV  output  1  HI/LO-pair select; equals RFWr.
REQ-012 SHALL expose port: WData  output  64  {HI, LO} result; HI in [63:32], LO in [31:0].

Function
REQ-013 SHALL implement the states IDLE, CALC and DONE.
REQ-014 IDLE with start=1 SHALL latch op, operand magnitudes and sign flags, load the iteration counter with 31, and go to CALC on the next edge.
REQ-015 CALC SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) for exactly 32 cycles, then go to DONE.
REQ-016 DONE SHALL last one cycle with RFWr=MDIV=1 and WData valid, then return to IDLE.
REQ-017 Latency: for start accepted at cycle N, CALC SHALL occupy cycles N+1..N+32, DONE SHALL be cycle N+33, and a new start SHALL be accepted no earlier than cycle N+34.
REQ-018 start asserted while busy=1 SHALL be ignored, with no queueing.
REQ-019 MULT/MULTU SHALL produce the exact 64-bit product (signed for MULT, unsigned for MULTU).
REQ-020 DIV/DIVU SHALL produce HI=remainder and LO=quotient, with truncation toward zero.
REQ-021 For signed divide, the quotient SHALL be negative iff the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero (src_b=0, either divide op) SHALL give HI=src_a and LO=32'hFFFFFFFF, with normal latency.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give HI=0 and LO=32'h80000000, with no exception.
REQ-024 flush=1 in CALC or DONE SHALL force IDLE on the next edge with RFWr=0 in that next cycle.
REQ-025 flush in IDLE SHALL have no effect, and flush SHALL take priority over a simultaneous start.
REQ-026 WData SHALL hold its last value outside DONE; consumers SHALL qualify it with RFWr.
REQ-027 RFWr SHALL be high for exactly one cycle per completed operation and never in IDLE or CALC.

Reset
REQ-028 rst=1 at any clock edge SHALL force IDLE, busy=0, RFWr=0, MDIV=0, WData=0 and counter=0, overriding start and flush.
REQ-029 rst asserted mid-CALC SHALL discard the operation, so that no RFWr follows.
REQ-030 The first start accepted after rst deasserts SHALL behave identically to a start after power-up.

Structure
REQ-031 A shared package SHALL hold the op encodings (MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3), the state encoding, and the iteration count constant 32.
REQ-032 One sub-module, mdu_step, SHALL be purely combinational and compute a single multiply/divide iteration from accumulator, operand and mode.
REQ-033 The sign fix-up and the divide-by-zero override SHALL be applied in the CALC-to-DONE transition, not in mdu_step.

Verification
REQ-034 SHALL test MULT src_a=7, src_b=32'hFFFFFFFD -> at N+33 RFWr=1 and WData=64'hFFFFFFFF_FFFFFFEB.
REQ-035 SHALL test MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> WData=64'hFFFFFFFE_00000001.
REQ-036 SHALL test DIV -7 / 2 -> WData=64'hFFFFFFFF_FFFFFFFD; and DIVU 100 / 7 -> WData=64'h00000002_0000000E.
REQ-037 SHALL test DIVU 5 / 0 -> WData=64'h00000005_FFFFFFFF; and DIV 32'h80000000 / -1 -> WData=64'h00000000_80000000.
REQ-038 SHALL test a second start at N+5 during busy -> ignored, with exactly one RFWr at N+33.
REQ-039 SHALL test rst at N+10 (and separately flush at N+10) -> busy=0 from N+11, with no RFWr through N+40.

Source files
------------

// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state encodings,
// the iteration count and an operand-magnitude helper.
package hilo_mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam int unsigned MDU_ITERS = 32;
  localparam int unsigned CNT_W     = 5;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_ITERS - 1);

  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/hilo_mdu_step.sv
// One radix-2 iteration on {HI, LO}: shift-add for multiply (LO holds the
// multiplier), restoring shift-subtract for divide (LO holds the quotient).
module mdu_step
  import hilo_mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [63:0] acc_o
);

  logic [32:0] add_sum;
  logic [32:0] shl_rem;
  logic [31:0] trial;

  // The shifted remainder can reach 33 bits; the subtraction only matters when it
  // fits, so its low 32 bits are exact.
  always_comb begin
    add_sum = {1'b0, acc_i[63:32]} + {1'b0, operand_i};
    shl_rem = {acc_i[63:32], acc_i[31]};
    trial   = shl_rem[31:0] - operand_i;
    acc_o   = acc_i;
    if (is_div_op(op_i)) begin
      if (shl_rem >= {1'b0, operand_i}) begin
        acc_o = {trial, acc_i[30:0], 1'b1};
      end else begin
        acc_o = {shl_rem[31:0], acc_i[30:0], 1'b0};
      end
    end else if (acc_i[0]) begin
      acc_o = {add_sum, acc_i[31:1]};
    end else begin
      acc_o = {1'b0, acc_i[63:1]};
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit writing {HI, LO} with a one-cycle
// strobe; works on magnitudes and restores signs when leaving CALC.
module hilo_mdu
  import hilo_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        RFWr,
  output logic        MDIV,
  output logic [63:0] WData
);

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q;
  logic [63:0]      acc_q;
  logic [31:0]      operand_q;
  logic             neg_a_q, neg_b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      wdata_q;

  mdu_op_e          start_op;
  logic             start_neg_a, start_neg_b;
  logic [31:0]      start_mag_a, start_mag_b;
  logic [63:0]      step_acc;
  logic [63:0]      result_d;
  logic [31:0]      quo_fix, rem_fix;

  mdu_step u_step (
    .op_i      (op_q),
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .acc_o     (step_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    RFWr  = (state_q == ST_DONE);
    MDIV  = (state_q == ST_DONE);
    WData = wdata_q;
  end

  always_comb begin
    start_op    = mdu_op_e'(op);
    start_neg_a = is_signed_op(start_op) & src_a[31];
    start_neg_b = is_signed_op(start_op) & src_b[31];
    start_mag_a = start_neg_a ? (32'd0 - src_a) : src_a;
    start_mag_b = start_neg_b ? (32'd0 - src_b) : src_b;
  end

  // A zero divisor leaves the dividend magnitude in HI, so the usual remainder
  // sign restore already yields src_a; only LO needs the all-ones override.
  always_comb begin
    quo_fix  = step_acc[31:0];
    rem_fix  = step_acc[63:32];
    result_d = step_acc;
    if (is_div_op(op_q)) begin
      quo_fix = (neg_a_q ^ neg_b_q) ? (32'd0 - step_acc[31:0]) : step_acc[31:0];
      rem_fix = neg_a_q ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
      if (operand_q == '0) begin
        quo_fix = '1;
      end
      result_d = {rem_fix, quo_fix};
    end else if (neg_a_q ^ neg_b_q) begin
      result_d = 64'd0 - step_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= MDU_MULT;
      acc_q     <= '0;
      operand_q <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      cnt_q     <= '0;
      wdata_q   <= '0;
    end else if (state_q == ST_IDLE && start) begin
      op_q    <= start_op;
      neg_a_q <= start_neg_a;
      neg_b_q <= start_neg_b;
      cnt_q   <= CNT_LOAD;
      if (is_div_op(start_op)) begin
        acc_q     <= {32'd0, start_mag_a};
        operand_q <= start_mag_b;
      end else begin
        acc_q     <= {32'd0, start_mag_b};
        operand_q <= start_mag_a;
      end
    end else if (state_q == ST_CALC && !flush) begin
      acc_q <= step_acc;
      if (cnt_q == '0) begin
        wdata_q <= result_d;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: reset state, arithmetic vectors with latency,
// ignored start while busy, and rst/flush aborts.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, RFWr, MDIV;
  logic [63:0] WData;

  int nCompared   = 0;
  int nMismatched = 0;

  localparam int NV = 10;
  logic [1:0]  vOp  [NV] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd2, 2'd1};
  logic [31:0] vA   [NV] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'd5,
                             32'h80000000, 32'd7, 32'h80000000, 32'hFFFFFFFB, 32'h12345678};
  logic [31:0] vB   [NV] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd7, 32'd0,
                             32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'd0, 32'h10};
  logic [63:0] vExp [NV] = '{64'hFFFFFFFF_FFFFFFEB, 64'hFFFFFFFE_00000001,
                             64'hFFFFFFFF_FFFFFFFD, 64'h00000002_0000000E,
                             64'h00000005_FFFFFFFF, 64'h00000000_80000000,
                             64'h00000001_FFFFFFFD, 64'h40000000_00000000,
                             64'hFFFFFFFB_FFFFFFFF, 64'h00000001_23456780};

  always #5 clk = ~clk;

  hilo_mdu dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .busy  (busy),
    .RFWr  (RFWr),
    .MDIV  (MDIV),
    .WData (WData)
  );

  // Reset must win over start and flush held high at the same time.
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; flush = 1'b1; op = 2'd1;
    src_a = 32'h1234; src_b = 32'h5678;
    repeat (3) @(negedge clk);
    nCompared++;
    if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    nCompared++;
    if (RFWr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rfwr: got %b want 0", RFWr); end
    nCompared++;
    if (MDIV !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mdiv: got %b want 0", MDIV); end
    nCompared++;
    if (WData !== 64'd0) begin nMismatched++; $display("[TB] FAIL reset_wdata: got %h want 0", WData); end
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    nCompared++;
    if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  // Vectors run back to back: each start is issued in the first IDLE cycle (N+34).
  task automatic test_arith();
    int cyc;
    for (int i = 0; i < NV; i++) begin
      start = 1'b1; op = vOp[i]; src_a = vA[i]; src_b = vB[i];
      @(negedge clk);
      start = 1'b0; src_a = 32'hDEADBEEF; src_b = 32'hCAFEF00D;
      cyc = 1;
      nCompared++;
      if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL arith%0d_busy: got %b want 1", i, busy); end
      while (!RFWr && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      nCompared++;
      if (cyc !== 33) begin nMismatched++; $display("[TB] FAIL arith%0d_latency: got %0d want 33", i, cyc); end
      nCompared++;
      if (WData !== vExp[i]) begin nMismatched++; $display("[TB] FAIL arith%0d_wdata: got %h want %h", i, WData, vExp[i]); end
      nCompared++;
      if (MDIV !== 1'b1 || busy !== 1'b1) begin
        nMismatched++; $display("[TB] FAIL arith%0d_done: got mdiv=%b busy=%b want 1/1", i, MDIV, busy);
      end
      @(negedge clk);
      nCompared++;
      if (RFWr !== 1'b0 || busy !== 1'b0) begin
        nMismatched++; $display("[TB] FAIL arith%0d_after: got rfwr=%b busy=%b want 0/0", i, RFWr, busy);
      end
      nCompared++;
      if (WData !== vExp[i]) begin nMismatched++; $display("[TB] FAIL arith%0d_hold: got %h want %h", i, WData, vExp[i]); end
    end
  endtask

  // A second start at N+5 must be dropped: one strobe at N+33 with the first result.
  task automatic test_busy_start();
    int pulses = 0;
    int pulseCyc = 0;
    logic [63:0] got = '0;
    start = 1'b1; op = 2'd1; src_a = 32'd3; src_b = 32'd5;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 5) begin
        start = 1'b1; op = 2'd3; src_a = 32'd100; src_b = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (RFWr) begin
        pulses++; pulseCyc = cyc; got = WData;
      end
    end
    start = 1'b0;
    nCompared++;
    if (pulses !== 1) begin nMismatched++; $display("[TB] FAIL busy_start_pulses: got %0d want 1", pulses); end
    nCompared++;
    if (pulseCyc !== 33) begin nMismatched++; $display("[TB] FAIL busy_start_cycle: got %0d want 33", pulseCyc); end
    nCompared++;
    if (got !== 64'h0000000F) begin nMismatched++; $display("[TB] FAIL busy_start_wdata: got %h want %h", got, 64'h0000000F); end
  endtask

  // Abort at N+10 by rst or flush: idle from N+11, no strobe through N+40.
  task automatic test_abort(input bit useRst, input logic [63:0] expWData);
    int pulses = 0;
    start = 1'b1; op = 2'd1; src_a = 32'hFFFFFFFF; src_b = 32'd2;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 10) begin
        nCompared++;
        if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort%0d_prebusy: got %b want 1", useRst, busy); end
        if (useRst) rst = 1'b1; else flush = 1'b1;
      end else begin
        rst = 1'b0; flush = 1'b0;
      end
      if (cyc == 11) begin
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort%0d_busy: got %b want 0", useRst, busy); end
      end
      if (RFWr) pulses++;
    end
    nCompared++;
    if (pulses !== 0) begin nMismatched++; $display("[TB] FAIL abort%0d_rfwr: got %0d strobes want 0", useRst, pulses); end
    nCompared++;
    if (WData !== expWData) begin nMismatched++; $display("[TB] FAIL abort%0d_wdata: got %h want %h", useRst, WData, expWData); end
  endtask

  // First operation after a reset must behave exactly like one after power-up.
  task automatic test_after_reset();
    int cyc;
    start = 1'b1; op = 2'd0; src_a = 32'd7; src_b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!RFWr && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    nCompared++;
    if (cyc !== 33) begin nMismatched++; $display("[TB] FAIL post_reset_latency: got %0d want 33", cyc); end
    nCompared++;
    if (WData !== 64'hFFFFFFFF_FFFFFFEB) begin
      nMismatched++; $display("[TB] FAIL post_reset_wdata: got %h want %h", WData, 64'hFFFFFFFF_FFFFFFEB);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_busy_start();
    test_abort(1'b0, 64'h0000000F);
    test_abort(1'b1, 64'd0);
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
